// File: rtl/bp_cce_gpr_wr_sched.sv
// GPR write-port scheduler: microcode writes win the port, directory writebacks are
// buffered in a circular FIFO and drained in arrival order. Optional macro: BP_CCE_GPR_WR_BYPASS_EN.
module bp_cce_gpr_wr_sched #(
  parameter int num_gpr_p   = 16,
  parameter int gpr_width_p = 64,
  parameter int fifo_els_p  = 2,
  localparam int gpr_sel_width_lp = $clog2(num_gpr_p),
  localparam int cnt_width_lp     = $clog2(fifo_els_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        ucode_w_v_i,
  input  logic [num_gpr_p-1:0]        ucode_w_mask_i,
  input  logic [gpr_width_p-1:0]      ucode_w_data_i,
  input  logic [num_gpr_p-1:0]        ucode_rd_mask_i,
  input  logic                        dir_v_i,
  input  logic [gpr_sel_width_lp-1:0] dir_gpr_i,
  input  logic [gpr_width_p-1:0]      dir_data_i,
  output logic                        dir_ready_o,
  output logic                        hazard_o,
  output logic [num_gpr_p-1:0]        gpr_w_mask_o,
  output logic [gpr_width_p-1:0]      gpr_w_data_o,
  output logic [cnt_width_lp-1:0]     pending_cnt_o
);

  localparam int ptr_width_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;

  logic [gpr_sel_width_lp-1:0] fifo_gpr_r  [fifo_els_p];
  logic [gpr_width_p-1:0]      fifo_data_r [fifo_els_p];
  logic [fifo_els_p-1:0]       fifo_v_r;
  logic [ptr_width_lp-1:0]     rd_ptr_r, wr_ptr_r;
  logic [cnt_width_lp-1:0]     cnt_r;

  logic                 fifo_full, fifo_empty;
  logic [num_gpr_p-1:0] pend_mask;
  logic [num_gpr_p-1:0] ucode_touch_mask;
  logic                 ucode_go;
  logic                 bypass;
  logic                 enq, pop;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    if (p == ptr_width_lp'(fifo_els_p - 1))
      return '0;
    else
      return p + ptr_width_lp'(1);
  endfunction

  function automatic logic [num_gpr_p-1:0] gpr_onehot(input logic [gpr_sel_width_lp-1:0] sel);
    return num_gpr_p'(1) << sel;
  endfunction

  assign fifo_full  = (cnt_r == cnt_width_lp'(fifo_els_p));
  assign fifo_empty = (cnt_r == '0);

  // Per-entry valid bits avoid modulo arithmetic on rd_ptr+offset for non-power-of-two depths.
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < fifo_els_p; i++) begin
      if (fifo_v_r[i])
        pend_mask = pend_mask | gpr_onehot(fifo_gpr_r[i]);
    end
  end

  assign ucode_touch_mask = ucode_rd_mask_i | (ucode_w_v_i ? ucode_w_mask_i : '0);
  assign hazard_o         = |(pend_mask & ucode_touch_mask);
  assign ucode_go         = ucode_w_v_i & (|ucode_w_mask_i) & ~hazard_o;

`ifdef BP_CCE_GPR_WR_BYPASS_EN
  assign bypass = fifo_empty & ~ucode_go & dir_v_i & ~reset_i;
`else
  assign bypass = 1'b0;
`endif

  assign dir_ready_o   = ~fifo_full | bypass;
  assign enq           = dir_v_i & dir_ready_o & ~bypass;
  assign pop           = ~ucode_go & ~fifo_empty;
  assign pending_cnt_o = cnt_r;

  // Buffered entries are discarded by reset, so the drain path is gated in the reset cycle.
  always_comb begin
    gpr_w_mask_o = '0;
    gpr_w_data_o = '0;
    if (ucode_go) begin
      gpr_w_mask_o = ucode_w_mask_i;
      gpr_w_data_o = ucode_w_data_i;
    end else if (~fifo_empty & ~reset_i) begin
      gpr_w_mask_o = gpr_onehot(fifo_gpr_r[rd_ptr_r]);
      gpr_w_data_o = fifo_data_r[rd_ptr_r];
    end else if (bypass) begin
      gpr_w_mask_o = gpr_onehot(dir_gpr_i);
      gpr_w_data_o = dir_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      cnt_r    <= '0;
      fifo_v_r <= '0;
    end else begin
      if (enq)
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop)
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (enq & ~pop)
        cnt_r <= cnt_r + cnt_width_lp'(1);
      else if (pop & ~enq)
        cnt_r <= cnt_r - cnt_width_lp'(1);
      for (int unsigned i = 0; i < fifo_els_p; i++) begin
        if (enq && (wr_ptr_r == ptr_width_lp'(i)))
          fifo_v_r[i] <= 1'b1;
        else if (pop && (rd_ptr_r == ptr_width_lp'(i)))
          fifo_v_r[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_gpr_r[wr_ptr_r]  <= dir_gpr_i;
      fifo_data_r[wr_ptr_r] <= dir_data_i;
    end
  end

endmodule

// File: doc/bp_cce_gpr_wr_sched.md
# bp_cce_gpr_wr_sched

Write-port scheduler for the CCE general-purpose register file. It arbitrates between microcode instruction writes and asynchronous directory address writebacks (RDE results). Directory writebacks are buffered in a small FIFO and drained into free write slots. Read-after-write and write-after-write hazards against buffered entries are flagged so the microcode front end can stall.

## Interface
Parameters:
- num_gpr_p, 16, number of GPRs; power of two, at least 2
- gpr_width_p, 64, GPR data width
- fifo_els_p, 2, depth of the directory writeback FIFO; at least 1
- Derived: gpr_sel_width_lp = clog2(num_gpr_p); cnt_width_lp = clog2(fifo_els_p+1)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset. Synchronous, active-high. Sampled on the rising edge of clk_i.
- ucode_w_v_i  in  1  microcode instruction requests a GPR write this cycle
- ucode_w_mask_i  in  num_gpr_p  one-hot-or-zero GPR destination mask
- ucode_w_data_i  in  gpr_width_p  microcode write data
- ucode_rd_mask_i  in  num_gpr_p  GPRs sourced by the current instruction
- dir_v_i  in  1  directory writeback valid
- dir_gpr_i  in  gpr_sel_width_lp  writeback destination GPR
- dir_data_i  in  gpr_width_p  writeback data; the zero-extended address
- dir_ready_o  out  1  FIFO can accept a writeback
- hazard_o  out  1  current instruction conflicts with a buffered writeback
- gpr_w_mask_o  out  num_gpr_p  register file write enables
- gpr_w_data_o  out  gpr_width_p  register file write data
- pending_cnt_o  out  cnt_width_lp  number of buffered writebacks

## Operation
- The FIFO is circular with rd_ptr, wr_ptr, and cnt. Each entry holds {gpr, data}.
- Enqueue happens when dir_v_i & dir_ready_o. dir_ready_o = (cnt != fifo_els_p), or the bypass condition when the macro is defined.
- pend_mask is the OR over valid FIFO entries of onehot(entry.gpr).
- hazard_o = |(pend_mask & (ucode_rd_mask_i | (ucode_w_v_i ? ucode_w_mask_i : 0))).
- ucode_go = ucode_w_v_i & |ucode_w_mask_i & ~hazard_o.
- Write select, in priority order:
  1. ucode_go: gpr_w_mask_o = ucode_w_mask_i, data = ucode_w_data_i.
  2. Else if cnt != 0: drain the head. mask = onehot(head.gpr), data = head.data. Pop.
  3. Else if bypass applies (macro only): the incoming writeback is written directly.
  4. Else: mask = 0 and data = 0.
- While hazard_o is asserted, the microcode write is suppressed. The front end must hold the instruction; it re-presents the same inputs next cycle.
- A simultaneous enqueue and pop leaves cnt unchanged. Both pointers advance and wrap at fifo_els_p.
- When the FIFO is full, dir_ready_o = 0. The directory must hold dir_v_i, dir_gpr_i, and dir_data_i stable until accepted.
- Ordering guarantee: writebacks retire in arrival order. A microcode write never lands on a GPR that still has a buffered older writeback.

## Timing
- Reset values: cnt = 0, rd_ptr = 0, wr_ptr = 0, pending_cnt_o = 0, dir_ready_o = 1, hazard_o = 0. gpr_w_mask_o = 0 unless ucode_w_v_i is asserted.
- All outputs are combinational from the inputs and FIFO state. State updates on the rising edge.
- Writeback latency, without bypass: at least 1 cycle. It is enqueued at edge N and written at cycle N+1 at the earliest, if no microcode write occupies the port.
- Drain rate: one entry per cycle whenever the port is free.
- Starvation: with continuous ucode_go, the FIFO never drains. Any microcode access to a pending GPR raises hazard_o, which frees the port.
- Reset asserted mid-operation discards all buffered entries at that edge. No write is issued from them.

## Configuration
- BP_CCE_GPR_WR_BYPASS_EN defined:
  - When cnt == 0, ucode_go == 0, and dir_v_i is asserted, the writeback goes straight to the write port in the same cycle and is not enqueued.
  - dir_ready_o = 1 in that case even if fifo_els_p would otherwise block it.
- BP_CCE_GPR_WR_BYPASS_EN undefined: every writeback is enqueued, with a minimum 1-cycle latency.

## Test plan
- Idle writeback: reset, dir_v_i = 1, gpr 3, data 0x8000_1000, no ucode activity.
  - Without the macro: cycle 0 has mask 0 and cnt becomes 1. Cycle 1 has mask 0x0008, data 0x8000_1000, and cnt returns to 0.
  - With the macro: mask 0x0008 in cycle 0 and cnt stays 0.
- Contention: ucode writes gpr 1 (data 0xA) continuously for 3 cycles while writebacks to gpr 4 and then gpr 5 arrive.
  - Ucode wins all 3 cycles; cnt = 2 and dir_ready_o = 0.
  - When ucode drops, gpr 4 and then gpr 5 are written on consecutive cycles.
- RAW hazard: buffered writeback to gpr 2; ucode_rd_mask_i = 0x0004 and a ucode write to gpr 7.
  - hazard_o = 1 and the ucode write is suppressed; gpr 2 drains.
  - Next cycle hazard_o = 0 and the gpr 7 write issues.
- WAW hazard: buffered writeback to gpr 6 with data 0x11; ucode writes gpr 6 with data 0x22.
  - Cycle 0: mask 0x0040, data 0x11, hazard_o = 1.
  - Cycle 1: mask 0x0040, data 0x22. The final value is 0x22.
- Wrap and full, with fifo_els_p = 2: push 5 writebacks back-to-back while ucode blocks the port for 4 cycles.
  - dir_ready_o deasserts at cnt = 2.
  - All 5 retire in order with correct GPR and data after the pointers wrap.
- Reset mid-operation: cnt = 2, assert reset_i for 1 cycle.
  - Next cycle: cnt = 0, dir_ready_o = 1, and no drain writes issue.
